mul32_seq: RTL and testbench
============================

// Module: mul32_seq
// PURPOSE
//   Sequential shift-add multiplier, the multiply counterpart of the iterative divider in the
//   arithmetic unit. Forms one product bit-slice per clock and uses the same start/finish
//   handshake as the divider, so the two can share issue logic.
//   Sits beside the divider behind the ALU multiplex; the result is read as high/low halves.
// PARAMETERS
//   WIDTH   32   operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//   clk           input   1        system clock, rising edge
//   rst           input   1        synchronous reset, active-high
//   multiplicand  input   WIDTH    operand A, sampled only on the accepted start cycle
//   multiplier    input   WIDTH    operand B, sampled only on the accepted start cycle
//   start         input   1        single-cycle request pulse
//   product_hi    output  WIDTH    product[2*WIDTH-1:WIDTH]
//   product_lo    output  WIDTH    product[WIDTH-1:0]
//   busy          output  1        high while iterating
//   finish        output  1        high when the product is valid; held until the next accepted start
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state=IDLE, busy=0, finish=0, product_hi=0, product_lo=0,
//     count=0. Overrides all other inputs, including start and an operation in flight.
//     A reset mid-operation aborts it; no finish pulse follows.
//   - States: IDLE -> BUSY on start; BUSY -> DONE when count reaches WIDTH-1;
//     DONE -> BUSY on start; DONE otherwise holds.
//   - Accept: start=1 in IDLE or DONE. On that edge:
//     - latch A into mcand_r and B into the low half of the accumulator;
//     - clear the high half and the carry;
//     - count=0, busy=1, finish=0.
//   - start=1 while BUSY is ignored; the operation in flight and its operands are unaffected.
//   - BUSY iteration, one per cycle, over a (2*WIDTH+1)-bit register {carry, hi, lo}:
//     - if lo[0]=1, then {carry, hi} = hi + mcand_r, an unsigned (WIDTH+1)-bit sum;
//     - then shift {carry, hi, lo} right by 1; the vacated msb gets 0.
//     - count increments each iteration.
//   - Latency: start is accepted at edge k. Iterations run at edges k+1 .. k+WIDTH.
//     At edge k+WIDTH: busy=0, finish=1, state=DONE.
//     finish is therefore visible WIDTH cycles after the accepted start (32 at default).
//   - Latency is fixed and data-independent; no early termination on zero operands.
//   - product_hi/product_lo show the working register during BUSY. Only values with finish=1
//     are architecturally valid; they are held stable in DONE.
//   - Unsigned arithmetic; the full 2*WIDTH product never overflows.
//   - Back-to-back: start on the same cycle finish is observed is accepted and clears finish
//     on that edge.
// CONFIGURATION
//   SIGNED_MUL_EN (macro)
//   - Undefined:
//     - inputs are unsigned; the port list is as above.
//   - Defined:
//     - adds input port is_signed (1 bit), sampled with the operands.
//     - When is_signed=1, the operands are taken as two's complement. Magnitudes are latched
//       at accept and the sign is XOR of the operand msbs.
//     - The 2*WIDTH result is negated on the final iteration edge when the sign is 1.
//     - Latency is unchanged.
//     - The most-negative operand (e.g. 0x80000000) uses its unsigned magnitude 2^(WIDTH-1),
//       and the result is exact.
//     - When is_signed=0, behaviour is identical to the undefined build.
// TESTING
//   1. Reset during BUSY (start, then rst at cycle 10) -> busy=0, finish=0, products 0; no finish afterwards.
//   2. A=0x0000_0007, B=0x0000_0006, start pulse -> finish exactly 32 cycles later; hi=0, lo=0x2A.
//   3. A=B=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; A=0, B=0x1234 -> 0; latency is 32 in every case.
//   4. start re-pulsed at cycle 5 with A=3, B=3 during an 7x6 operation -> ignored; result 0x2A at cycle 32.
//   5. start on the finish cycle with A=2, B=5 -> finish drops next edge; hi=0, lo=0xA after 32 more cycles.
//   6. SIGNED_MUL_EN, is_signed=1:
//      - A=-3 (0xFFFF_FFFD), B=5 -> {hi,lo}=0xFFFF_FFFF_FFFF_FFF1;
//      - A=B=0x8000_0000 -> hi=0x4000_0000, lo=0.

Source files
------------

// File: rtl/mul32_seq_if.sv
// Operand/result bundle for the sequential multiplier.
// Carries the optional is_signed input when SIGNED_MUL_EN is defined.
interface mul32_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             start;
`ifdef SIGNED_MUL_EN
    logic             is_signed;
`endif
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
    logic             busy;
    logic             finish;

`ifdef SIGNED_MUL_EN
    modport master (output multiplicand, multiplier, start, is_signed,
                    input  product_hi, product_lo, busy, finish);
    modport slave  (input  multiplicand, multiplier, start, is_signed,
                    output product_hi, product_lo, busy, finish);
`else
    modport master (output multiplicand, multiplier, start,
                    input  product_hi, product_lo, busy, finish);
    modport slave  (input  multiplicand, multiplier, start,
                    output product_hi, product_lo, busy, finish);
`endif
endinterface

// File: rtl/mul32_seq.sv
// Sequential shift-add multiplier: one product bit per clock, WIDTH cycles per operation.
// Shares the start/finish handshake of the iterative divider.
// Optional feature macro: SIGNED_MUL_EN (adds is_signed; magnitude multiply + final negate).
module mul32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    mul32_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // {carry, hi, lo}: lo starts as the multiplier and is consumed from bit 0
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   step;
    logic               last;
`ifdef SIGNED_MUL_EN
    logic               sign_q, sign_d;
    logic               neg_a, neg_b;

    // Two's-complement operands are reduced to magnitudes; the most-negative
    // value maps onto its unsigned magnitude 2^(WIDTH-1) naturally.
    assign neg_a = bus.is_signed & bus.multiplicand[WIDTH-1];
    assign neg_b = bus.is_signed & bus.multiplier[WIDTH-1];
    assign mag_a = neg_a ? (-bus.multiplicand) : bus.multiplicand;
    assign mag_b = neg_b ? (-bus.multiplier)   : bus.multiplier;
`else
    assign mag_a = bus.multiplicand;
    assign mag_b = bus.multiplier;
`endif

    // One iteration: conditional add into the high half, then shift right with 0 fill.
    assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign step = acc_q[0] ? ({sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
    assign last = (count_q == CW'(WIDTH - 1));

    // Next-state: accept in IDLE/DONE, iterate in BUSY, start ignored while BUSY.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
`ifdef SIGNED_MUL_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = BUSY;
                    count_d = '0;
                    mcand_d = mag_a;
                    acc_d   = {1'b0, {WIDTH{1'b0}}, mag_b};
`ifdef SIGNED_MUL_EN
                    sign_d  = neg_a ^ neg_b;
`endif
                end
            end
            BUSY: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (last) begin
                    state_d = DONE;
`ifdef SIGNED_MUL_EN
                    // Negation folds into the final iteration so latency is unchanged.
                    if (sign_q) acc_d = {1'b0, -step[2*WIDTH-1:0]};
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
`ifdef SIGNED_MUL_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
`ifdef SIGNED_MUL_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign bus.busy       = (state_q == BUSY);
    assign bus.finish     = (state_q == DONE);
    assign bus.product_hi = acc_q[2*WIDTH-1:WIDTH];
    assign bus.product_lo = acc_q[WIDTH-1:0];
endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: expected products queued at start, checked at finish.
// Define SIGNED_MUL_EN to also exercise the signed build.
module tb_mul32_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul32_seq_if #(.WIDTH(W)) bus ();
    mul32_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns #1 after the accepting edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
        bus.multiplicand = a;
        bus.multiplier   = b;
`ifdef SIGNED_MUL_EN
        bus.is_signed    = s;
`endif
        bus.start        = 1'b1;
        if (push) sb_q.push_back(model(a, b, s));
        tick();
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for finish; cyc0 = cycles already elapsed since accept.
    task automatic wait_done(input string tag, input int cyc0);
        int cyc = cyc0;
        while (!bus.finish && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd32);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
        end else begin
            last_exp = sb_q.pop_front();
            chk({tag, "_prod"}, {bus.product_hi, bus.product_lo}, last_exp);
        end
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
`ifdef SIGNED_MUL_EN
        bus.is_signed = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_finish", 64'(bus.finish), 64'd0);
        chk("rst_prod",   {bus.product_hi, bus.product_lo}, 64'd0);
        rst = 1'b0;
        tick();

        // Reset mid-operation aborts with no finish afterwards
        pulse(32'd7, 32'd6, 1'b0, 1'b0);
        repeat (9) tick();
        chk("mid_busy_pre", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   64'(bus.busy),   64'd0);
        chk("abort_finish", 64'(bus.finish), 64'd0);
        chk("abort_prod",   {bus.product_hi, bus.product_lo}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.finish) seen = 1'b1;
        end
        chk("abort_no_finish", 64'(seen), 64'd0);

        // Basic product and hold stability in DONE
        pulse(32'd7, 32'd6, 1'b0, 1'b1);
        wait_done("7x6", 0);
        repeat (3) tick();
        chk("hold_prod",   {bus.product_hi, bus.product_lo}, last_exp);
        chk("hold_finish", 64'(bus.finish), 64'd1);

        // Extremes and zero operand, fixed latency
        pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("max", 0);
        chk("max_const", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFE_0000_0001);
        pulse(32'h0, 32'h1234, 1'b0, 1'b1);
        wait_done("zero", 0);

        // start while BUSY is ignored
        pulse(32'd7, 32'd6, 1'b0, 1'b1);
        repeat (4) tick();
        pulse(32'd3, 32'd3, 1'b0, 1'b0);
        wait_done("ignore", 5);
        chk("ignore_const", {bus.product_hi, bus.product_lo}, 64'h2A);

        // Back-to-back start on the finish cycle
        pulse(32'd2, 32'd5, 1'b0, 1'b1);
        chk("b2b_finish_drop", 64'(bus.finish), 64'd0);
        chk("b2b_busy",        64'(bus.busy),   64'd1);
        wait_done("b2b", 0);

        // Random unsigned operands
        for (int i = 0; i < 4; i++) begin
            pulse($urandom, $urandom, 1'b0, 1'b1);
            wait_done("rnd", 0);
        end

`ifdef SIGNED_MUL_EN
        pulse(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        wait_done("s_neg3x5", 0);
        chk("s_neg3x5_const", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        pulse(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done("s_minmin", 0);
        chk("s_minmin_const", {bus.product_hi, bus.product_lo}, 64'h4000_0000_0000_0000);
        pulse(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        wait_done("s_off", 0);
        for (int i = 0; i < 3; i++) begin
            pulse($urandom, $urandom, 1'b1, 1'b1);
            wait_done("s_rnd", 0);
        end
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
